// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory/writeback stage: FSM states, op classes and
// the captured-op record passed from execute into mem/wb.
package cpu_pkg;

   // Op record fields are sized for the widest supported datapath.
   localparam int OP_DATA_W = 32;
   localparam int OP_REG_AW = 8;

   typedef enum logic [1:0] {IDLE, MEM_WAIT, BUS_WAIT, WB} memwb_state_e;
   typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_BUS} op_class_e;

   typedef struct packed {
      logic [OP_DATA_W-1:0] addr;
      logic [OP_DATA_W-1:0] data;
      logic [OP_REG_AW-1:0] dest;
      logic                 alutoreg;
      logic                 memtoreg;
      logic                 bustoreg;
      op_class_e            cls;
   } memwb_op_t;

   // Bus traffic outranks loads, loads outrank stores, everything else is ALU.
   function automatic op_class_e classifyOp(input logic bustoreg, input logic buswrite,
                                            input logic memread, input logic memtoreg,
                                            input logic memwrite);
      op_class_e cls;
      cls = OP_ALU;
      if (bustoreg || buswrite)
         cls = OP_BUS;
      else if (memread || memtoreg)
         cls = OP_LOAD;
      else if (memwrite)
         cls = OP_STORE;
      return cls;
   endfunction

endpackage

// File: rtl/memwb_bus_if.sv
// Accelerator-bus requester: holds req/addr/data stable until ack or timeout
// and keeps the sticky timeout error flag.
module memwb_bus_if
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int BUS_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_ack,
   input  logic [DATA_W-1:0] i_rdata,
   output logic              o_req,
   output logic              o_we,
   output logic [DATA_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_err
);

   localparam int CW = $clog2(BUS_TIMEOUT);

   logic [CW-1:0] r_cnt;
   logic          w_expire;

   // An ack in the expiry cycle still counts as a normal completion.
   assign w_expire = (r_cnt == CW'(BUS_TIMEOUT - 1));
   assign o_done   = o_req && (i_ack || w_expire);
   assign o_rdata  = (o_req && i_ack) ? i_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_req   <= 1'b0;
         o_we    <= 1'b0;
         o_addr  <= '0;
         o_wdata <= '0;
         r_cnt   <= '0;
         o_err   <= 1'b0;
      end else if (o_req) begin
         if (o_done) begin
            o_req   <= 1'b0;
            o_we    <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
            r_cnt   <= '0;
            if (!i_ack)
               o_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else if (i_start) begin
         o_req   <= 1'b1;
         o_we    <= i_we;
         o_addr  <= i_addr;
         o_wdata <= i_wdata;
         r_cnt   <= '0;
      end
   end

endmodule

// File: rtl/cpu_memwb_unit.sv
// CPU mem/wb stage: accepts one op per handshake, runs BRAM or accelerator-bus
// access, and issues a single registered writeback pulse.
module cpu_memwb_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int REG_AW      = 4,
   parameter int DMEM_LAT    = 1,
   parameter int BUS_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic [DATA_W-1:0] ex_data2,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              ex_alutoreg,
   input  logic              ex_memtoreg,
   input  logic              ex_bustoreg,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic              ex_buswrite,
   output logic              dmem_ren,
   output logic              dmem_wren,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_data_to,
   input  logic [DATA_W-1:0] dmem_data_from,
   output logic              bus_req,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data_out,
   input  logic [DATA_W-1:0] bus_data_in,
   input  logic              bus_ack,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              bus_err
);

   memwb_state_e      r_state;
   memwb_op_t         r_op;
   memwb_op_t         w_op;
   logic [2:0]        r_latCnt;
   logic              w_accept;
   logic              w_busStart;
   logic              w_busDone;
   logic [DATA_W-1:0] w_busRdata;
   logic              w_unused;

   always_comb begin
      w_op          = '0;
      w_op.addr     = OP_DATA_W'(ex_alu_out);
      w_op.data     = OP_DATA_W'(ex_data2);
      w_op.dest     = OP_REG_AW'(ex_dest);
      w_op.alutoreg = ex_alutoreg;
      w_op.memtoreg = ex_memtoreg;
      w_op.bustoreg = ex_bustoreg;
      w_op.cls      = classifyOp(ex_bustoreg, ex_buswrite, ex_memread, ex_memtoreg, ex_memwrite);
   end

   assign w_accept   = ex_valid && ex_ready;
   assign w_busStart = w_accept && (w_op.cls == OP_BUS);
   assign w_unused   = ^r_op;

   memwb_bus_if #(
      .DATA_W      (DATA_W),
      .BUS_TIMEOUT (BUS_TIMEOUT)
   ) u_busIf (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_busStart),
      .i_we    (ex_buswrite),
      .i_addr  (ex_alu_out),
      .i_wdata (ex_data2),
      .i_ack   (bus_ack),
      .i_rdata (bus_data_in),
      .o_req   (bus_req),
      .o_we    (bus_we),
      .o_addr  (bus_addr),
      .o_wdata (bus_data_out),
      .o_done  (w_busDone),
      .o_rdata (w_busRdata),
      .o_err   (bus_err)
   );

   // Pulse-style outputs fall back to zero every cycle unless re-armed below.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_op         <= '0;
         r_latCnt     <= '0;
         ex_ready     <= 1'b1;
         dmem_ren     <= 1'b0;
         dmem_wren    <= 1'b0;
         dmem_addr    <= '0;
         dmem_data_to <= '0;
         wb_en        <= 1'b0;
         wb_dest      <= '0;
         wb_data      <= '0;
      end else begin
         dmem_ren     <= 1'b0;
         dmem_wren    <= 1'b0;
         dmem_addr    <= '0;
         dmem_data_to <= '0;
         wb_en        <= 1'b0;
         wb_dest      <= '0;
         wb_data      <= '0;
         case (r_state)
            IDLE, WB: begin
               r_state <= IDLE;
               if (w_accept) begin
                  r_op <= w_op;
                  case (w_op.cls)
                     OP_ALU: begin
                        if (ex_alutoreg) begin
                           wb_en   <= 1'b1;
                           wb_dest <= ex_dest;
                           wb_data <= ex_alu_out;
                        end
                     end
                     OP_STORE: begin
                        dmem_wren    <= 1'b1;
                        dmem_addr    <= ex_alu_out;
                        dmem_data_to <= ex_data2;
                     end
                     OP_LOAD: begin
                        dmem_ren  <= 1'b1;
                        dmem_addr <= ex_alu_out;
                        r_latCnt  <= '0;
                        ex_ready  <= 1'b0;
                        r_state   <= MEM_WAIT;
                     end
                     OP_BUS: begin
                        ex_ready <= 1'b0;
                        r_state  <= BUS_WAIT;
                     end
                     default: r_state <= IDLE;
                  endcase
               end
            end
            MEM_WAIT: begin
               if (r_latCnt == 3'(DMEM_LAT - 1)) begin
                  wb_en    <= 1'b1;
                  wb_dest  <= r_op.dest[REG_AW-1:0];
                  wb_data  <= dmem_data_from;
                  ex_ready <= 1'b1;
                  r_state  <= WB;
               end else begin
                  r_latCnt <= r_latCnt + 3'd1;
               end
            end
            BUS_WAIT: begin
               if (w_busDone) begin
                  ex_ready <= 1'b1;
                  if (r_op.bustoreg) begin
                     wb_en   <= 1'b1;
                     wb_dest <= r_op.dest[REG_AW-1:0];
                     wb_data <= w_busRdata;
                     r_state <= WB;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cpu_memwb_unit.md
Name: cpu_memwb_unit

Overview:
Parametrised successor to the CPU's inline mem/wb logic. Accepts one op per handshake from the execute stage and performs a data-BRAM read or write with configurable read latency, or an accelerator-bus transaction with a req/ack handshake and timeout. It then produces a single prioritised writeback to the register file. It back-pressures fetch/decode and execute through ex_ready, replacing the fixed one-cycle load stall.

Parameters:
DATA_W, 16, datapath and address width
REG_AW, 4, register-file address width
DMEM_LAT, 1, BRAM read latency in cycles (1..4)
BUS_TIMEOUT, 64, cycles to wait for bus_ack before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  unit can accept an op this cycle
ex_alu_out  in  DATA_W  ALU result; memory/bus address
ex_data2  in  DATA_W  store/bus-write data
ex_dest  in  REG_AW  writeback destination
ex_alutoreg / ex_memtoreg / ex_bustoreg  in  1 each  writeback source select
ex_memread / ex_memwrite / ex_buswrite  in  1 each  operation type
dmem_ren / dmem_wren  out  1 each  BRAM enables
dmem_addr / dmem_data_to  out  DATA_W each  BRAM address and store data
dmem_data_from  in  DATA_W  BRAM read data
bus_req / bus_we  out  1 each  accelerator request and write flag
bus_addr / bus_data_out  out  DATA_W each  accelerator address and write data
bus_data_in  in  DATA_W  accelerator read data
bus_ack  in  1  accelerator completion
wb_en  out  1  register-file write enable
wb_dest  out  REG_AW  writeback address
wb_data  out  DATA_W  writeback data
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst high at a clk edge) sets all outputs to 0 except ex_ready=1, returns the FSM to IDLE, clears the timeout and latency counters, drops any in-flight op and clears bus_err. A bus_ack arriving after reset is ignored.
- Accept: the op is captured into an internal op register when ex_valid && ex_ready at an edge (cycle N). ex_valid while ex_ready=0 is ignored; upstream holds it.
- Op class, in priority order: bus if ex_bustoreg|ex_buswrite; else load if ex_memread|ex_memtoreg; else store if ex_memwrite; else ALU.
- Writeback source priority if several are set: bus > mem > alu.
- FSM states: IDLE, MEM_WAIT, BUS_WAIT, WB.
- ALU op: cycle N+1 gives wb_en=ex_alutoreg, wb_data=alu_out. FSM stays in IDLE and ex_ready=1, so back-to-back throughput is 1/cycle.
- Store: cycle N+1 gives dmem_wren=1 for exactly 1 cycle with dmem_addr and dmem_data_to. No writeback. ex_ready stays 1.
- Load:
  - Cycle N+1: dmem_ren=1 for exactly 1 cycle; FSM enters MEM_WAIT.
  - dmem_data_from is sampled DMEM_LAT cycles after ren.
  - Cycle N+1+DMEM_LAT: wb_en=1 with the sampled data, state WB.
  - ex_ready=0 from N+1 through N+DMEM_LAT and 1 in the WB cycle. The next op is accepted at the end of the WB cycle.
- Bus op:
  - From N+1, bus_req=1 with bus_we=ex_buswrite, bus_addr and bus_data_out held stable until ack or abort.
  - On bus_ack while bus_req=1: drop req the next cycle. If bustoreg, capture bus_data_in on the ack edge and assert wb_en the next cycle. A write ack returns to IDLE with no writeback.
  - ex_ready=0 while in BUS_WAIT.
  - bus_ack while bus_req=0 is ignored.
- Timeout: a counter starts at 0 at N+1. If no ack has arrived after BUS_TIMEOUT cycles of req, drop req, set bus_err=1 (sticky), and if bustoreg write back wb_data=0. An ack in the same cycle as the timeout wins (normal completion).
- wb_en is a single-cycle pulse. wb_dest and wb_data are 0 when wb_en=0.
- Address and data are passed through as-is at DATA_W bits, with no address arithmetic.

Decomposition:
- cpu_pkg holds:
  - memwb_state_e {IDLE, MEM_WAIT, BUS_WAIT, WB};
  - op_class_e {OP_ALU, OP_LOAD, OP_STORE, OP_BUS};
  - the memwb_op_t struct (addr, data, dest, wb-source bits, class).
- One sub-module, memwb_bus_if, holds the req/ack/timeout counter and the bus_err register.

Test Plan:
- rst held 2 cycles, then released → ex_ready=1, all other outputs 0, bus_err=0.
- Back-to-back ALU ops: dest 3 data 0x1234, then dest 5 data 0xBEEF → wb_en on consecutive cycles with matching dest/data; ex_ready never drops.
- With DMEM_LAT=2: load addr 0x0040, BRAM returns 0xA5A5 → dmem_ren one cycle at N+1, wb_en at N+3 with dest and data 0xA5A5; ex_ready low for 2 cycles.
- Bus read addr 0x0010, ack after 5 cycles with data 0x7777 → bus_req high 5 cycles, wb_data=0x7777 on the following cycle. Bus write data 0x0101 → no wb_en.
- Bus read with no ack and BUS_TIMEOUT=8 → req drops after 8 cycles, wb_data=0, bus_err=1 and remains set; a later ALU op still completes.
- rst asserted mid-load in MEM_WAIT → next cycle: no wb_en ever fires for that load, ex_ready=1, state IDLE.
